// File: rtl/koa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : koa_pkg
//  Brief    : Shared FSM encoding and width helper for the sequential KOA multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
package koa_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    MID  = 3'd3,
    SUM  = 3'd4,
    DONE = 3'd5
  } koa_state_e;

  function automatic int koa_half(input int width);
    return width / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/koa_base_mult.sv
`default_nettype none
// ============================================================================
//  Module   : koa_base_mult
//  Brief    : Combinational unsigned WIDTH x WIDTH multiplier shared by all passes.
//  Revision : 1.0 - initial release
// ============================================================================
module koa_base_mult #(
  parameter int WIDTH = 65
) (
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] p
);

  assign p = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};

endmodule
`default_nettype wire

// File: rtl/koa_multiplier_seq.sv
`default_nettype none
// ============================================================================
//  Module   : koa_multiplier_seq
//  Brief    : One-level Karatsuba multiplier; one base multiplier reused over
//             three cycles. Optional macro KOA_ZERO_SKIP_EN short-circuits
//             zero operands straight to DONE.
//  Revision : 1.0 - initial release
// ============================================================================
module koa_multiplier_seq
  import koa_pkg::*;
#(
  parameter int DATA_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int HALF = koa_half(DATA_WIDTH);
  localparam int MW   = HALF + 1;

  generate
    if ((DATA_WIDTH % 2) != 0 || DATA_WIDTH < 4) begin : g_bad_width
      $error("koa_multiplier_seq: DATA_WIDTH must be even and >= 4");
    end
  endgenerate

  koa_state_e state, state_nx;

  logic [DATA_WIDTH-1:0]   a_q, b_q, z0, z2;
  logic [DATA_WIDTH+1:0]   z1m, mid;
  logic [2*DATA_WIDTH-1:0] product_q, mid_ext, sum_full;
  logic [HALF-1:0]         al, ah, bl, bh;
  logic [MW-1:0]           mx, my;
  logic [2*MW-1:0]         mp;
  logic                    accept, zero_skip;

  assign al = a_q[HALF-1:0];
  assign ah = a_q[DATA_WIDTH-1:HALF];
  assign bl = b_q[HALF-1:0];
  assign bh = b_q[DATA_WIDTH-1:HALF];

  assign accept = in_valid && (state == IDLE);

`ifdef KOA_ZERO_SKIP_EN
  assign zero_skip = (a == '0) || (b == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // Operand mux: the single base multiplier serves LO, HI and MID in turn.
  always_comb begin
    mx = '0;
    my = '0;
    case (state)
      LO: begin
        mx = {1'b0, al};
        my = {1'b0, bl};
      end
      HI: begin
        mx = {1'b0, ah};
        my = {1'b0, bh};
      end
      MID: begin
        mx = {1'b0, al} + {1'b0, ah};
        my = {1'b0, bl} + {1'b0, bh};
      end
      default: ;
    endcase
  end

  koa_base_mult #(.WIDTH(MW)) u_base_mult (
    .x (mx),
    .y (my),
    .p (mp)
  );

  // {z2,z0} places z2 at DATA_WIDTH and z0 at 0 without a separate adder.
  assign mid      = z1m - {2'b00, z2} - {2'b00, z0};
  assign mid_ext  = {{(DATA_WIDTH-2){1'b0}}, mid};
  assign sum_full = {z2, z0} + (mid_ext << HALF);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = zero_skip ? DONE : LO;
      LO:      state_nx = HI;
      HI:      state_nx = MID;
      MID:     state_nx = SUM;
      SUM:     state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      z0        <= '0;
      z2        <= '0;
      z1m       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q <= a;
          b_q <= b;
          if (zero_skip) product_q <= '0;
        end
        LO:      z0        <= mp[DATA_WIDTH-1:0];
        HI:      z2        <= mp[DATA_WIDTH-1:0];
        MID:     z1m       <= mp;
        SUM:     product_q <= sum_full;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign product   = product_q;

endmodule
`default_nettype wire
